// File: rtl/dcache_pkg.sv
// dcache_pkg: shared definitions for the direct-mapped data cache controller.
//   - default address/data widths, line count, index and tag widths
//   - controller state enumeration (explicit, legacy-compatible encodings)
//   - saturating 8-bit increment used by the hit/miss counters
package dcache_pkg;

  localparam int ADDR_W_DEFAULT = 8;
  localparam int DATA_W_DEFAULT = 8;
  localparam int LINES          = 4;
  localparam int INDEX_W        = 2;
  localparam int TAG_W          = ADDR_W_DEFAULT - INDEX_W;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    MISS_RD   = 3'd1,
    MISS_WAIT = 3'd2,
    WR_THRU   = 3'd3,
    RESP      = 3'd4
  } state_t;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/dcache_line_store.sv
// dcache_line_store: valid/tag/data storage for the 4-line direct-mapped cache.
//   clk, clr        : clock; synchronous clear of all valid bits (priority over write)
//   wr_en, wr_idx,
//   wr_tag, wr_data : single write port; a write marks the line valid
//   rd_idx          : combinational read index
//   rd_valid, rd_tag,
//   rd_data         : combinational read port
// Tags and data are not reset; only the valid bits are.
module dcache_line_store
  import dcache_pkg::*;
#(
  parameter int TAG_BITS = TAG_W,
  parameter int DATA_W   = DATA_W_DEFAULT
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                wr_en,
  input  logic [INDEX_W-1:0]  wr_idx,
  input  logic [TAG_BITS-1:0] wr_tag,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [INDEX_W-1:0]  rd_idx,
  output logic                rd_valid,
  output logic [TAG_BITS-1:0] rd_tag,
  output logic [DATA_W-1:0]   rd_data
);

  logic [LINES-1:0]    valid;
  logic [TAG_BITS-1:0] tag_mem  [LINES];
  logic [DATA_W-1:0]   data_mem [LINES];

  always_ff @(posedge clk) begin
    if (clr) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_data;
    end
  end

  always_comb begin
    rd_valid = valid[rd_idx];
    rd_tag   = tag_mem[rd_idx];
    rd_data  = data_mem[rd_idx];
  end

endmodule

// File: rtl/dcache_controller.sv
// dcache_controller: 4-line direct-mapped, write-through/no-allocate data cache.
//   clk, clr          : clock, synchronous active-high reset
//   req, we, addr,
//   wdata             : CPU request (held until ready), write flag, address, data
//   inv               : invalidate all lines at this edge
//   rdata, ready      : read data (valid while ready), one-cycle completion pulse
//   ram_addr, ram_ce,
//   ram_rw, ram_wdata : D_RAM request, decoded from state only
//   ram_rdata         : D_RAM read data, valid the cycle after a read ce
//   hit_cnt, miss_cnt : saturating read hit/miss counters
module dcache_controller
  import dcache_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              inv,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_ce,
  output logic              ram_rw,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [7:0]        hit_cnt,
  output logic [7:0]        miss_cnt
);

  localparam int TAG_BITS = ADDR_W - INDEX_W;

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic [ADDR_W-1:0]   look_addr;
  logic                line_valid;
  logic [TAG_BITS-1:0] line_tag;
  logic [DATA_W-1:0]   line_data;
  logic                hit;
  logic                st_we;
  logic [DATA_W-1:0]   st_wdata;

  // In IDLE the lookup uses the incoming address so a read hit can answer
  // with latency 1; in every other state it uses the latched address.
  assign look_addr = (state == IDLE) ? addr : addr_q;
  assign hit       = line_valid && (line_tag == look_addr[ADDR_W-1:INDEX_W]);

  // Fill on MISS_WAIT->RESP, update only on a write hit at WR_THRU->RESP.
  // A coincident inv still clears the valid bit inside the store.
  assign st_we    = !clr && ((state == MISS_WAIT) || (state == WR_THRU && hit));
  assign st_wdata = (state == MISS_WAIT) ? ram_rdata : wdata_q;

  dcache_line_store #(
    .TAG_BITS (TAG_BITS),
    .DATA_W   (DATA_W)
  ) u_store (
    .clk      (clk),
    .clr      (clr || inv),
    .wr_en    (st_we),
    .wr_idx   (addr_q[INDEX_W-1:0]),
    .wr_tag   (addr_q[ADDR_W-1:INDEX_W]),
    .wr_data  (st_wdata),
    .rd_idx   (look_addr[INDEX_W-1:0]),
    .rd_valid (line_valid),
    .rd_tag   (line_tag),
    .rd_data  (line_data)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      state    <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata    <= '0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            addr_q  <= addr;
            wdata_q <= wdata;
            if (we) begin
              state <= WR_THRU;
            end else if (hit) begin
              state   <= RESP;
              rdata   <= line_data;
              hit_cnt <= sat_inc(hit_cnt);
            end else begin
              state    <= MISS_RD;
              miss_cnt <= sat_inc(miss_cnt);
            end
          end
        end
        MISS_RD:   state <= MISS_WAIT;
        MISS_WAIT: begin
          rdata <= ram_rdata;
          state <= RESP;
        end
        WR_THRU:   state <= RESP;
        RESP:      state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

  always_comb begin
    ready     = (state == RESP);
    ram_ce    = (state == MISS_RD) || (state == WR_THRU);
    ram_rw    = (state != WR_THRU);
    ram_addr  = addr_q;
    ram_wdata = wdata_q;
  end

endmodule

// File: tb/tb_dcache_controller.sv
// tb_dcache_controller: directed + randomized bench for dcache_controller.
// The reference model tracks cache lines as plain arrays and memory as a
// separate array, and predicts hit/miss, latency, read data and counters.
module tb_dcache_controller;

  logic       clk = 1'b0;
  logic       clr, req, we, inv;
  logic [7:0] addr, wdata, rdata, ram_addr, ram_wdata, ram_rdata;
  logic       ready, ram_ce, ram_rw;
  logic [7:0] hit_cnt, miss_cnt;

  always #5 clk = ~clk;

  dcache_controller #(
    .ADDR_W (8),
    .DATA_W (8)
  ) dut (
    .clk       (clk),
    .clr       (clr),
    .req       (req),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .inv       (inv),
    .rdata     (rdata),
    .ready     (ready),
    .ram_addr  (ram_addr),
    .ram_ce    (ram_ce),
    .ram_rw    (ram_rw),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt)
  );

  // D_RAM environment: loaded from seed_mem while ram_load is high.
  logic [7:0] seed_mem [256];
  logic [7:0] mem      [256];
  logic       ram_load;

  always @(posedge clk) begin
    if (ram_load) begin
      mem <= seed_mem;
    end else begin
      if (ram_ce && ram_rw)  ram_rdata <= mem[ram_addr];
      if (ram_ce && !ram_rw) mem[ram_addr] <= ram_wdata;
    end
  end

  // Reference model
  logic [7:0] ref_mem [256];
  bit         m_valid [4];
  logic [5:0] m_tag   [4];
  logic [7:0] m_data  [4];
  int         m_hits, m_misses;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void model_invalidate();
    for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;
  endfunction

  // One CPU access. inv_fill pulses inv so it lands on the MISS_WAIT->RESP edge.
  task automatic access(input bit wr, input logic [7:0] a, input logic [7:0] d,
                        input bit inv_fill);
    int         idx, lat, exp_lat;
    bit         hit, seen, uses_ram;
    logic [7:0] exp_data, rdata_before;
    idx          = int'(a[1:0]);
    hit          = m_valid[idx] && (m_tag[idx] == a[7:2]);
    exp_lat      = wr ? 2 : (hit ? 1 : 3);
    uses_ram     = wr || !hit;
    exp_data     = hit ? m_data[idx] : ref_mem[a];
    rdata_before = rdata;
    seen         = 1'b0;
    lat          = 99;

    @(negedge clk);
    req = 1'b1; we = wr; addr = a; wdata = d;
    @(posedge clk);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) begin
        check("ram_ce_c1", ram_ce, uses_ram);
        if (uses_ram) begin
          check("ram_addr", ram_addr, a);
          check("ram_rw", ram_rw, !wr);
        end
        if (wr) check("ram_wdata", ram_wdata, d);
      end
      if (inv_fill && k == 2) inv = 1'b1;
      if (k == 3) inv = 1'b0;
      if (ready) begin
        seen = 1'b1;
        lat  = k;
        break;
      end
    end
    req = 1'b0;
    inv = 1'b0;
    check(wr ? "wr_latency" : "rd_latency", seen ? lat : 99, exp_lat);
    if (wr) check("rdata_hold_on_wr", rdata, rdata_before);
    else    check("rdata", rdata, exp_data);

    if (wr) begin
      ref_mem[a] = d;
      if (hit) m_data[idx] = d;
    end else if (hit) begin
      if (m_hits < 255) m_hits++;
    end else begin
      if (m_misses < 255) m_misses++;
      if (inv_fill) begin
        model_invalidate();
      end else begin
        m_valid[idx] = 1'b1;
        m_tag[idx]   = a[7:2];
        m_data[idx]  = exp_data;
      end
    end
    check("hit_cnt", hit_cnt, m_hits);
    check("miss_cnt", miss_cnt, m_misses);
  endtask

  task automatic idle_inv();
    @(negedge clk);
    inv = 1'b1;
    @(negedge clk);
    inv = 1'b0;
    model_invalidate();
  endtask

  // Write whose WR_THRU cycle is hit by clr; data equals memory contents so
  // the RAM image is the same whether or not the write-through landed.
  task automatic abort_write(input logic [7:0] a);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = a; wdata = ref_mem[a];
    @(posedge clk);
    @(negedge clk);
    check("abort_ram_ce", ram_ce, 1);
    check("abort_ram_rw", ram_rw, 0);
    clr = 1'b1;
    req = 1'b0;
    @(negedge clk);
    clr = 1'b0;
    check("abort_ready", ready, 0);
    check("abort_ce_off", ram_ce, 0);
    check("abort_hit_cnt", hit_cnt, 0);
    check("abort_miss_cnt", miss_cnt, 0);
    check("abort_rdata", rdata, 0);
    @(negedge clk);
    check("abort_ready2", ready, 0);
    check("abort_ce_off2", ram_ce, 0);
    model_invalidate();
    m_hits   = 0;
    m_misses = 0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      seed_mem[i] = 8'($urandom);
    end
    seed_mem[8'h13] = 8'hA5;
    for (int i = 0; i < 256; i++) ref_mem[i] = seed_mem[i];
    model_invalidate();
    m_hits = 0; m_misses = 0;

    clr = 1'b1; ram_load = 1'b1; req = 1'b0; we = 1'b0; inv = 1'b0;
    addr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    clr = 1'b0; ram_load = 1'b0;
    @(negedge clk);
    check("rst_ready", ready, 0);
    check("rst_rdata", rdata, 0);
    check("rst_hit_cnt", hit_cnt, 0);
    check("rst_miss_cnt", miss_cnt, 0);
    check("rst_ram_ce", ram_ce, 0);

    // Directed scenarios
    access(1'b0, 8'h13, 8'h00, 1'b0);   // miss, A5
    check("first_miss_data", rdata, 8'hA5);
    access(1'b0, 8'h13, 8'h00, 1'b0);   // hit
    access(1'b1, 8'h13, 8'h5C, 1'b0);   // write-through hit
    access(1'b0, 8'h13, 8'h00, 1'b0);   // hit, 5C
    check("read_after_write", rdata, 8'h5C);
    access(1'b0, 8'h17, 8'h00, 1'b0);   // alias index 3
    access(1'b0, 8'h13, 8'h00, 1'b0);   // miss again
    access(1'b0, 8'h20, 8'h00, 1'b1);   // inv on fill edge
    access(1'b0, 8'h20, 8'h00, 1'b0);   // misses again
    access(1'b1, 8'h44, 8'h3C, 1'b0);   // write miss, no allocate
    access(1'b0, 8'h44, 8'h00, 1'b0);   // miss returns written data
    check("wr_miss_then_rd", rdata, 8'h3C);

    // Randomized traffic over a small address window to force aliasing
    for (int n = 0; n < 250; n++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r == 0) idle_inv();
      else access(r < 4, 8'($urandom_range(0, 31)), 8'($urandom),
                  ($urandom_range(0, 15) == 0));
    end

    abort_write(8'h13);
    access(1'b0, 8'h40, 8'h00, 1'b0);   // miss after abort
    for (int n = 0; n < 300; n++) access(1'b0, 8'h40, 8'h00, 1'b0);
    check("hit_cnt_saturated", hit_cnt, 255);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
